// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared state type, SPI mode decode and default idle word
package spi_target_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [7:0] IDLE_PATTERN_DEFAULT = 8'hFF;
  function automatic logic cpol(input int mode);
    return mode[1];
  endfunction
  function automatic logic cpha(input int mode);
    return mode[0];
  endfunction
endpackage

// File: rtl/spi_target_sync.sv
// spi_target_sync: 3-bit multi-stage synchroniser with per-bit reset values
module spi_target_sync #(
  parameter int STAGES = 2,
  parameter logic [2:0] RST_VAL = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] d,
  output logic [2:0] q
);
  logic [2:0] stage [STAGES];
  // shift the raw inputs through STAGES flops
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  assign q = stage[STAGES-1];
endmodule

// File: rtl/spi_target.sv
// spi_target: oversampled SPI target with valid/ready byte interface; SPI_TARGET_ECHO_EN echoes last rx on underrun
module spi_target
  import spi_target_pkg::*;
#(
  parameter int FRAME_SIZE = 8,
  parameter int MOT_MODE = 3,
  parameter int SYNC_STAGES = 2,
  parameter logic [31:0] IDLE_PATTERN = 32'(IDLE_PATTERN_DEFAULT)
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  SPICLKI,
  input  logic                  SPISSI,
  input  logic                  SPISDI,
  output logic                  SPISDO,
  output logic                  SPIOEN,
  input  logic [FRAME_SIZE-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [FRAME_SIZE-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort,
  output logic                  busy
);
  localparam logic CPOL = cpol(MOT_MODE);
  localparam logic CPHA = cpha(MOT_MODE);
  localparam int CW = $clog2(FRAME_SIZE);
  localparam logic [CW-1:0] LAST = CW'(FRAME_SIZE - 1);
  state_t state;
  logic sclk_s, ss_s, sdi_s, sclk_q;
  logic [CW-1:0] bit_cnt;
  logic [FRAME_SIZE-1:0] tx_shift, hold, underrun_word, rx_next;
  logic [FRAME_SIZE-2:0] rx_shift;
  logic hold_full, loaded, need_load;
  logic rise, fall, sample_edge, shift_edge, start, load, shift, abort;
  spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL({CPOL, 1'b1, 1'b0})) u_sync (
    .clk(PCLK),
    .rst(PRESET),
    .d({SPICLKI, SPISSI, SPISDI}),
    .q({sclk_s, ss_s, sdi_s})
  );
`ifdef SPI_TARGET_ECHO_EN
  assign underrun_word = rx_data;
`else
  assign underrun_word = IDLE_PATTERN[FRAME_SIZE-1:0];
`endif
  assign rise = sclk_s & ~sclk_q;
  assign fall = ~sclk_s & sclk_q;
  assign sample_edge = (state == ACTIVE) & ~ss_s & ((CPOL == CPHA) ? rise : fall);
  assign shift_edge = (state == ACTIVE) & ~ss_s & ((CPOL == CPHA) ? fall : rise);
  assign start = (state == IDLE) & ~ss_s;
  assign load = CPHA ? (shift_edge & (bit_cnt == '0)) : (start | (shift_edge & need_load));
  assign shift = shift_edge & ~load;
  assign abort = (bit_cnt != '0) | (~CPHA & loaded);
  assign rx_next = {rx_shift, sdi_s};
  assign tx_ready = ~hold_full;
  assign busy = state == ACTIVE;
  assign SPIOEN = state == ACTIVE;
  assign SPISDO = (state == ACTIVE) & tx_shift[FRAME_SIZE-1];
  // holding register: capture when empty, drained by a frame-start load
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      hold <= '0;
      hold_full <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      hold <= tx_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  // frame FSM: shift/sample on qualified SCLK edges, SS deassert always wins
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      state <= IDLE;
      sclk_q <= CPOL;
      bit_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      loaded <= 1'b0;
      need_load <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      rx_valid <= 1'b0;
      frame_abort <= 1'b0;
      tx_underrun <= load & ~hold_full;
      if (load) begin
        tx_shift <= hold_full ? hold : underrun_word;
        loaded <= 1'b1;
        need_load <= 1'b0;
      end else if (shift) begin
        tx_shift <= tx_shift << 1;
      end
      if (start) begin
        state <= ACTIVE;
        bit_cnt <= '0;
      end else if (state == ACTIVE && ss_s) begin
        state <= IDLE;
        bit_cnt <= '0;
        frame_abort <= abort;
        loaded <= 1'b0;
        need_load <= 1'b0;
      end else if (sample_edge) begin
        rx_shift <= rx_next[FRAME_SIZE-2:0];
        bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
        if (bit_cnt == LAST) begin
          rx_data <= rx_next;
          rx_valid <= 1'b1;
          loaded <= 1'b0;
          need_load <= 1'b1;
        end
      end
    end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI target (slave) endpoint for the CORESPI master, which is configured as Motorola, mode 3, 8-bit frames, single SS.
- Sits in the PCLK fabric domain and oversamples SPISCLKI/SPISSI/SPISDI through synchronisers.
- Hands received frames and accepts transmit frames over a simple valid/ready byte interface.
- Used by on-board peripherals and bench models that answer the master's transfers.

Parameters:
- FRAME_SIZE, 8: bits per frame (4..32); MSB first.
- MOT_MODE, 3: SPI mode; bit1 = CPOL, bit0 = CPHA.
- SYNC_STAGES, 2: synchroniser depth for SPI inputs (2..3).
- IDLE_PATTERN, 8'hFF: word shifted out on TX underrun; zero-extended or truncated to FRAME_SIZE.

Ports:
- PCLK  in  1  system clock; SPI clock must be ≤ PCLK/8.
- PRESET  in  1  asynchronous reset, active-high.
- SPICLKI  in  1  SPI clock from master.
- SPISSI  in  1  target select, active-low.
- SPISDI  in  1  master-out data.
- SPISDO  out  1  target-out data.
- SPIOEN  out  1  SPISDO output enable, active-high.
- tx_data  in  FRAME_SIZE  next frame to transmit.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  holding register empty; transfer occurs when tx_valid & tx_ready.
- rx_data  out  FRAME_SIZE  last complete received frame, held until the next one.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- tx_underrun  out  1  one-cycle pulse, frame started with empty holding register.
- frame_abort  out  1  one-cycle pulse, SS deasserted mid-frame.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: SPISDO=0, SPIOEN=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_abort=0, busy=0. Synchroniser flops reset to SCLK=CPOL, SS=1, SDI=0.
- Edge detection: compare synced SCLK with its previous value; edges are qualified by synced SS low.
  - Sample edge: rising if CPOL==CPHA, else falling.
  - Shift edge: the other edge.
- Input-to-action latency: SYNC_STAGES+1 PCLK cycles.
- FSM states:
  - IDLE: wait for synced SS low.
  - ACTIVE: shifting.
  - On SS low: go to ACTIVE, bit_cnt=0, SPIOEN=1 in the same cycle.
- Frame-start load (tx_shift ← holding register, or IDLE_PATTERN plus a tx_underrun pulse if empty):
  - CPHA=0: on SS assertion, and on the first shift edge after each completed frame.
  - CPHA=1: on each shift edge with bit_cnt==0.
  - All other shift edges: tx_shift shifts left by 1.
- SPISDO = tx_shift[FRAME_SIZE-1] while ACTIVE, 0 in IDLE.
- Sample edge: rx_shift ← {rx_shift[FRAME_SIZE-2:0], SPISDI_sync}, bit_cnt+1.
  - At bit_cnt==FRAME_SIZE-1: rx_data ← assembled word, rx_valid pulses next cycle, bit_cnt wraps to 0. Back-to-back frames continue without SS deassertion.
- Holding register:
  - Captures on tx_valid & tx_ready; tx_ready=0 until consumed by a load.
  - Same-cycle load and capture with an empty register: the load takes IDLE_PATTERN (underrun), then the capture fills the register. No bypass.
- SS deassert while ACTIVE:
  - If bit_cnt!=0, or CPHA=0 and a load has happened since the last complete frame: frame_abort pulse, partial rx discarded, no rx_valid.
  - Always: go to IDLE, SPIOEN=0. The word already loaded in tx_shift is lost; the holding register is kept.
- A sample edge and SS deassert in the same PCLK cycle: the edge is ignored (SS wins).
- PRESET mid-frame: immediate return to reset values. The master sees SPIOEN drop.
- rx has no backpressure; the consumer must accept rx_valid pulses.

Optional Feature:
- SPI_TARGET_ECHO_EN defined: on underrun, tx_shift loads the last rx_data instead of IDLE_PATTERN. tx_underrun still pulses.
- Undefined: IDLE_PATTERN is used and the echo path is not synthesised.

Decomposition:
- spi_target_pkg: FSM state enum {IDLE, ACTIVE}, mode decode functions cpol()/cpha(), and the default IDLE_PATTERN constant.
- Sub-module spi_target_sync: parameterised SYNC_STAGES, 3-bit-wide synchroniser with per-bit reset values.

Test Plan:
- Mode 3, SCLK=PCLK/8: preload tx 8'hA5; master sends 8'h3C -> SPISDO bits 1,0,1,0,0,1,0,1 on falling edges; rx_valid once, rx_data=8'h3C; tx_ready returns to 1.
- No tx preloaded; master sends 8'h00 -> tx_underrun pulse, master reads 8'hFF. With SPI_TARGET_ECHO_EN and previous rx 8'h3C -> master reads 8'h3C.
- Three back-to-back frames under one SS (8'h11, 8'h22, 8'h33), tx fed 8'hC1, 8'hC2, 8'hC3 just in time -> three rx_valid pulses with matching data; master reads C1, C2, C3.
- SS deasserted after 5 bits -> frame_abort=1 for one cycle, no rx_valid, busy=0, SPIOEN=0; the next full frame is received correctly.
- MOT_MODE=0 instance: tx 8'h81 -> SPISDO=1 immediately after SS is seen low (before the first SCLK edge); master reads 8'h81.
- PRESET asserted mid-frame at bit 3 -> all outputs at reset values within one cycle; after release a new frame completes normally.
